data_sram_resp: RTL and testbench
=================================

Name: data_sram_resp

Overview:
Memory-side responder for the EX-stage data SRAM interface (en / byte-wen / addr / wdata), returning read data one cycle later for the MEM stage.
Contains a byte-writable single-port data RAM and a small memory-mapped config-register window: scratch, LED, free-running timer and store counter.
Flags illegal byte-enable patterns with a sticky error bit.
Used as the data memory in standalone core simulation and FPGA bring-up.

Parameters:
ADDR_W, 12, word-address bits of the data RAM (depth 2^ADDR_W words of 32 bits)
CONF_BASE, 32'hBFAF_0000, base address of the config window
CONF_MASK, 32'hFFFF_0000, address bits compared against CONF_BASE for a window hit

Ports:
clk  input  1  clock, all state updates on rising edge
resetn  input  1  synchronous active-low reset
data_sram_en  input  1  access request this cycle
data_sram_wen  input  4  byte write enables; 4'b0000 with en=1 is a read
data_sram_addr  input  32  byte address
data_sram_wdata  input  32  write data, already lane-aligned by EX
data_sram_rdata  output  32  registered read data, valid the cycle after a read request
led  output  16  LED register contents
err  output  1  sticky illegal-wen flag

Behaviour:
- Reset (resetn=0 at a rising edge):
  - rdata=0, led=0, scratch=0, timer=0, store_cnt=0, err=0.
  - RAM contents are not reset.
  - A request in a reset cycle is discarded: no write, no counter update.
- Decode:
  - conf_hit = ((addr & CONF_MASK) == (CONF_BASE & CONF_MASK)).
  - conf_hit has priority over RAM.
  - RAM index = addr[ADDR_W+1:2]; higher address bits alias (wrap) silently.
  - addr[1:0] is ignored; lane selection comes only from wen.
- Legal wen: 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - Any other value with en=1: no write occurs anywhere, rdata holds, err<=1 until reset.
- RAM write (en=1, legal wen≠0, !conf_hit): only bytes whose wen bit is set are updated at the edge.
- Read (en=1, wen=0):
  - rdata <= full 32-bit word at the index (RAM or conf register) at the edge.
  - Latency 1 cycle. No sign extension or byte extraction; that is MEM-stage work.
- rdata holds its previous value on idle cycles (en=0) and write cycles. There is no read-during-write return value.
- Back-to-back: a write at cycle N followed by a read of the same word at N+1 returns the new data at N+2.
- Config window, offset = addr[3:2]; addr[15:4] are ignored inside the window:
  - 0 scratch: read/write, byte-merged.
  - 1 led: read/write, byte-merged; only bits [15:0] are stored and reads return {16'b0, led}.
  - 2 timer: +1 every non-reset cycle, wraps at 32'hFFFF_FFFF -> 0.
    - A write loads the byte-merged value (merge base = current timer value) with no increment that cycle; the increment resumes next cycle.
    - A read returns the value before that edge's update.
  - 3 store_cnt: +1 for every legal write request (RAM or conf, including writes to store_cnt itself), wrapping at 32 bits.
    - A write to offset 3 clears it to 0; the clear wins over the increment.
- Simultaneous events: only one request per cycle (single port). Timer increment and a timer write in the same cycle: the write wins.

Test Plan:
- Reset then sw 0x11223344 to 0x0000_0010 (wen=1111), lw same addr -> rdata=0x11223344 two cycles after the sw; store_cnt=1.
- sb wen=0100 wdata=0x00AA0000 to that word, then lw -> rdata=0x11AA3344. sh wen=0011 wdata=0x0000BEEF, then lw -> 0x11AABEEF.
- Write 0x0000_5A5A to CONF_BASE+0x4 -> led=16'h5A5A next cycle. Write 0 to CONF_BASE+0xC, then read CONF_BASE+0xC -> 0.
- Write 0x0000_0100 to CONF_BASE+0x8 at cycle N, then read at N+3 -> rdata=0x0000_0102. Also load 0xFFFF_FFFF and confirm the wrap to 0 one cycle later.
- wen=0101 to a RAM word holding 0xCAFEF00D -> err=1, word still reads 0xCAFEF00D, store_cnt unchanged. err stays 1 until resetn=0.
- Address aliasing: write 0xDEAD0001 to 0x0000_0000, read 0x0000_4000 with ADDR_W=12 -> 0xDEAD0001. Assert resetn=0 coincident with a write -> word unchanged, rdata=0.

Source files
------------

// File: rtl/data_sram_resp_if.sv
// EX-stage data SRAM request/response bundle: en / byte-wen / addr / wdata out, rdata back.
interface data_sram_resp_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, output wen, output addr, output wdata, input rdata);
  modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_sram_resp.sv
// Data-memory responder: byte-writable RAM plus a config window holding scratch, LED,
// free-running timer and store counter; read data returns one cycle after the request.
module data_sram_resp #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] CONF_BASE = 32'hBFAF_0000,
  parameter logic [31:0] CONF_MASK = 32'hFFFF_0000
) (
  input  logic             clk,
  input  logic             resetn,
  data_sram_resp_if.slave  bus,
  output logic [15:0]      led,
  output logic             err
);

  localparam int DEPTH = 1 << ADDR_W;

  function automatic logic wen_legal(input logic [3:0] wen);
    logic ok;
    case (wen)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] base,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wen);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = wen[b] ? wdata[8*b +: 8] : base[8*b +: 8];
    end
    return res;
  endfunction

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       scratch_q, scratch_d;
  logic [15:0]       led_q, led_d;
  logic [31:0]       timer_q, timer_d;
  logic [31:0]       store_cnt_q, store_cnt_d;
  logic              err_q, err_d;

  logic              conf_hit_s;
  logic              is_read_s;
  logic              is_write_s;
  logic              is_illegal_s;
  logic              ram_we_s;
  logic [1:0]        conf_off_s;
  logic [ADDR_W-1:0] ram_idx_s;
  logic [31:0]       conf_rdata_s;
  logic              unused_addr_s;

  assign unused_addr_s = ^bus.addr;

  // Request decode: window hit, access kind and target index.
  always_comb begin
    conf_hit_s   = ((bus.addr & CONF_MASK) == (CONF_BASE & CONF_MASK));
    conf_off_s   = bus.addr[3:2];
    ram_idx_s    = bus.addr[ADDR_W+1:2];
    is_illegal_s = bus.en & ~wen_legal(bus.wen);
    is_read_s    = bus.en & (bus.wen == 4'b0000);
    is_write_s   = bus.en & wen_legal(bus.wen) & (bus.wen != 4'b0000);
    ram_we_s     = is_write_s & ~conf_hit_s;
  end

  // Config-window read mux; timer reads see the pre-update value.
  always_comb begin
    case (conf_off_s)
      2'd0:    conf_rdata_s = scratch_q;
      2'd1:    conf_rdata_s = {16'h0000, led_q};
      2'd2:    conf_rdata_s = timer_q;
      2'd3:    conf_rdata_s = store_cnt_q;
      default: conf_rdata_s = 32'h0000_0000;
    endcase
  end

  // Next-state for the response and config registers.
  always_comb begin
    rdata_d     = rdata_q;
    scratch_d   = scratch_q;
    led_d       = led_q;
    timer_d     = timer_q + 32'd1;
    store_cnt_d = store_cnt_q;
    err_d       = err_q | is_illegal_s;

    if (is_read_s) begin
      rdata_d = conf_hit_s ? conf_rdata_s : mem_q[ram_idx_s];
    end else begin
      rdata_d = rdata_q;
    end

    if (is_write_s) begin
      store_cnt_d = store_cnt_q + 32'd1;
    end else begin
      store_cnt_d = store_cnt_q;
    end

    // A config write overrides the free-running timer and the store-counter increment.
    if (is_write_s && conf_hit_s) begin
      case (conf_off_s)
        2'd0:    scratch_d   = byte_merge(scratch_q, bus.wdata, bus.wen);
        2'd1:    led_d       = {bus.wen[1] ? bus.wdata[15:8] : led_q[15:8],
                                bus.wen[0] ? bus.wdata[7:0]  : led_q[7:0]};
        2'd2:    timer_d     = byte_merge(timer_q, bus.wdata, bus.wen);
        2'd3:    store_cnt_d = 32'h0000_0000;
        default: scratch_d   = scratch_q;
      endcase
    end else begin
      scratch_d = scratch_q;
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q     <= 32'h0000_0000;
      scratch_q   <= 32'h0000_0000;
      led_q       <= 16'h0000;
      timer_q     <= 32'h0000_0000;
      store_cnt_q <= 32'h0000_0000;
      err_q       <= 1'b0;
    end else begin
      rdata_q     <= rdata_d;
      scratch_q   <= scratch_d;
      led_q       <= led_d;
      timer_q     <= timer_d;
      store_cnt_q <= store_cnt_d;
      err_q       <= err_d;
    end
  end

  // RAM array is never reset; writes are discarded during reset cycles.
  always_ff @(posedge clk) begin
    if (resetn && ram_we_s) begin
      mem_q[ram_idx_s] <= byte_merge(mem_q[ram_idx_s], bus.wdata, bus.wen);
    end
  end

  assign bus.rdata = rdata_q;
  assign led       = led_q;
  assign err       = err_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Randomised bench for data_sram_resp: a behavioural model of the memory map is stepped
// every edge and compared against the DUT on every falling edge, plus directed literal checks.
module tb_data_sram_resp;
  localparam logic [31:0] CONF_BASE = 32'hBFAF_0000;
  localparam logic [31:0] CONF_MASK = 32'hFFFF_0000;

  logic        clk;
  logic        resetn;
  logic [15:0] led;
  logic        err;

  data_sram_resp_if bus ();

  data_sram_resp #(.ADDR_W(12), .CONF_BASE(CONF_BASE), .CONF_MASK(CONF_MASK)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .led    (led),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Behavioural view of the memory map.
  logic [31:0] m_mem [4096];
  logic [31:0] m_rdata, m_scratch, m_timer, m_cnt;
  logic [15:0] m_led;
  logic        m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] wen);
    logic [31:0] mask;
    mask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
    return (old & ~mask) | (nw & mask);
  endfunction

  task automatic model_step(input logic rstn, input logic en, input logic [3:0] wen,
                            input logic [31:0] addr, input logic [31:0] wdata);
    logic        hit;
    logic [31:0] next_timer, tmp;
    int          idx;
    if (!rstn) begin
      m_rdata = 32'd0; m_scratch = 32'd0; m_led = 16'd0;
      m_timer = 32'd0; m_cnt = 32'd0; m_err = 1'b0;
    end else begin
      hit        = ((addr & CONF_MASK) == (CONF_BASE & CONF_MASK));
      idx        = int'(addr[13:2]);
      next_timer = m_timer + 32'd1;
      if (en) begin
        if (!(wen inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})) begin
          m_err = 1'b1;
        end else if (wen == 4'b0000) begin
          if (!hit) m_rdata = m_mem[idx];
          else if (addr[3:2] == 2'd0) m_rdata = m_scratch;
          else if (addr[3:2] == 2'd1) m_rdata = {16'd0, m_led};
          else if (addr[3:2] == 2'd2) m_rdata = m_timer;
          else m_rdata = m_cnt;
        end else begin
          m_cnt = m_cnt + 32'd1;
          if (!hit) m_mem[idx] = merge(m_mem[idx], wdata, wen);
          else if (addr[3:2] == 2'd0) m_scratch = merge(m_scratch, wdata, wen);
          else if (addr[3:2] == 2'd1) begin
            tmp   = merge({16'd0, m_led}, wdata, wen);
            m_led = tmp[15:0];
          end
          else if (addr[3:2] == 2'd2) next_timer = merge(m_timer, wdata, wen);
          else m_cnt = 32'd0;
        end
      end
      m_timer = next_timer;
    end
  endtask

  task automatic cycle(input logic rstn, input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
    resetn    = rstn;
    bus.en    = en;
    bus.wen   = wen;
    bus.addr  = addr;
    bus.wdata = wdata;
    @(posedge clk);
    model_step(rstn, en, wen, addr, wdata);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] d);
    cycle(1'b1, 1'b1, wen, addr, d);
  endtask

  task automatic rd(input logic [31:0] addr);
    cycle(1'b1, 1'b1, 4'b0000, addr, 32'd0);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 4'b0000, 32'd0, 32'd0);
  endtask

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rdata", bus.rdata, m_rdata);
      check("led", {16'd0, led}, {16'd0, m_led});
      check("err", {31'd0, err}, {31'd0, m_err});
    end
  end

  logic [3:0] legal_w [8]   = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  logic [3:0] illegal_w [4] = '{4'b0101, 4'b1010, 4'b0111, 4'b1001};

  initial begin
    logic [31:0] a, d;
    logic [3:0]  w;
    logic        rn, en;

    resetn = 1'b0; bus.en = 1'b0; bus.wen = 4'b0000; bus.addr = 32'd0; bus.wdata = 32'd0;
    cycle(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
    chk_en = 1'b1;
    cycle(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_led", {16'd0, led}, 32'h0);
    check("reset_err", {31'd0, err}, 32'h0);

    wr(32'h0000_0010, 4'b1111, 32'h1122_3344);
    rd(32'h0000_0010);
    check("sw_lw", bus.rdata, 32'h1122_3344);
    rd(CONF_BASE + 32'hC);
    check("store_cnt_1", bus.rdata, 32'h0000_0001);

    wr(32'h0000_0010, 4'b0100, 32'h00AA_0000);
    rd(32'h0000_0010);
    check("sb_lane2", bus.rdata, 32'h11AA_3344);
    wr(32'h0000_0010, 4'b0011, 32'h0000_BEEF);
    rd(32'h0000_0010);
    check("sh_low", bus.rdata, 32'h11AA_BEEF);

    wr(CONF_BASE + 32'h4, 4'b1111, 32'h0000_5A5A);
    check("led_write", {16'd0, led}, 32'h0000_5A5A);
    wr(CONF_BASE + 32'hC, 4'b1111, 32'h0);
    rd(CONF_BASE + 32'hC);
    check("store_cnt_clr", bus.rdata, 32'h0);

    wr(CONF_BASE + 32'h8, 4'b1111, 32'h0000_0100);
    idle();
    idle();
    rd(CONF_BASE + 32'h8);
    check("timer_n3", bus.rdata, 32'h0000_0102);
    wr(CONF_BASE + 32'h8, 4'b1111, 32'hFFFF_FFFF);
    rd(CONF_BASE + 32'h8);
    check("timer_max", bus.rdata, 32'hFFFF_FFFF);
    rd(CONF_BASE + 32'h8);
    check("timer_wrap", bus.rdata, 32'h0);

    wr(32'h0000_0020, 4'b1111, 32'hCAFE_F00D);
    wr(32'h0000_0020, 4'b0101, 32'h1234_5678);
    check("err_set", {31'd0, err}, 32'h1);
    rd(32'h0000_0020);
    check("illegal_nowrite", bus.rdata, 32'hCAFE_F00D);
    rd(CONF_BASE + 32'hC);
    check("illegal_nocount", bus.rdata, 32'h0000_0003);
    idle();
    check("err_sticky", {31'd0, err}, 32'h1);

    wr(32'h0000_0000, 4'b1111, 32'hDEAD_0001);
    rd(32'h0000_4000);
    check("alias", bus.rdata, 32'hDEAD_0001);
    cycle(1'b0, 1'b1, 4'b1111, 32'h0000_0000, 32'h1234_5678);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_err", {31'd0, err}, 32'h0);
    rd(32'h0000_0000);
    check("rst_nowrite", bus.rdata, 32'hDEAD_0001);

    for (int i = 0; i < 16; i++) wr(32'(i) << 2, 4'b1111, $urandom);

    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 99) != 0);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0)
        a = CONF_BASE | ($urandom & 32'h0000_FFFF);
      else
        a = (32'($urandom_range(0, 7)) << 14) | (32'($urandom_range(0, 15)) << 2)
            | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) w = illegal_w[$urandom_range(0, 3)];
      else if ($urandom_range(0, 1) == 0) w = 4'b0000;
      else w = legal_w[$urandom_range(1, 7)];
      d = $urandom;
      cycle(rn, en, w, a, d);
    end

    idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
